mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Stage directly downstream of the combinational ALU; consumes ALU_out, the ALU flags and the decoded op fields.
- Registers arithmetic/move results into the register-file write port and holds the architectural flag register.
- Runs LOAD/STORE against data memory over a req/ack handshake with a bounded wait, stalling upstream while busy.

Parameters:
- DW, 8, data width (matches ALU).
- RAW, 3, register-file address width.
- AW, 8, data-memory address width.
- MAX_WAIT, 15, cycles mem_req may stay unacknowledged before abort.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction result this cycle.
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready.
- alu_out  in  DW  ALU result.
- mem_addr_in  in  AW  memory address (ALU arg 1 path) for LOAD/STORE.
- store_data  in  DW  data to store (ALU arg 0 path).
- data_signifier  in  1  0 = arithmetic op, 1 = data op.
- alu_op_code  in  3  arithmetic opcode (kADD..kSUB).
- data_op_code  in  2  data opcode (kMOVE, kFLAG, kLOAD, kSTORE).
- dest_reg  in  RAW  destination register.
- reg_write  in  1  decoder requests RF write.
- zero_in, beven_in, parity_in, equal_in  in  1 each  ALU flags.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load; stable while mem_req.
- mem_addr  out  AW  stable while mem_req.
- mem_wdata  out  DW  stable while mem_req.
- mem_ack  in  1  memory completes request this cycle.
- mem_rdata  in  DW  load data, valid with mem_ack.
- rf_we  out  1  one-cycle RF write strobe.
- rf_waddr  out  RAW  write address.
- rf_wdata  out  DW  write data.
- flags  out  4  {EQUAL, PARITY, BEVEN, ZERO}, registered.
- mem_err  out  1  sticky timeout indicator.

Behaviour:
- Reset: all outputs 0, including in_ready, flags and mem_err. State = IDLE and wait counter = 0 on the first cycle after Reset deasserts.
- States:
  - IDLE: in_ready = 1.
  - MEM_REQ: in_ready = 0, mem_req = 1.
  - LOAD_WB: in_ready = 0.
- Non-memory op accepted in cycle N (arithmetic, MOVE, FLAG):
  - Cycle N+1: rf_we = reg_write, rf_waddr = dest_reg, rf_wdata = alu_out. State stays IDLE.
  - Back-to-back accepts give one write per cycle.
- CMP (alu_op_code == kCMP) never writes the RF, regardless of reg_write.
- Flag register: loads {equal_in, parity_in, beven_in, zero_in} at N+1 only for accepted arithmetic ops. Data ops leave flags unchanged.
- LOAD/STORE accepted in cycle N:
  - mem_addr, mem_wdata and mem_we are latched.
  - mem_req rises at N+1 and state goes to MEM_REQ.
  - A writeback pending from cycle N-1 still completes at N.
- MEM_REQ:
  - The wait counter increments each cycle mem_ack = 0.
  - On mem_ack = 1 (including the first req cycle), mem_req drops the next cycle.
  - STORE: return to IDLE with no RF write.
  - LOAD: capture mem_rdata and go to LOAD_WB.
- LOAD_WB: rf_we = reg_write, rf_waddr = dest_reg, rf_wdata = captured data for one cycle, then IDLE. Minimum LOAD occupancy is 3 cycles.
- Timeout: if the counter reaches MAX_WAIT with no ack:
  - mem_req drops and mem_err sets (sticky until Reset).
  - No RF write; return to IDLE; counter clears.
  - A late ack arriving in IDLE is ignored.
- mem_ack while mem_req = 0: ignored.
- in_valid while in_ready = 0: ignored; upstream must hold the instruction.
- Reset mid-transaction: mem_req and rf_we are 0 the next cycle. The pending load and writeback are discarded.

Decomposition:
- The shared definitions package already carries the ALU and data opcode constants (kCMP, kLOAD, kSTORE, etc.).
- Add to that package:
  - the mem_wb_state_t enum (IDLE, MEM_REQ, LOAD_WB);
  - the flag bit-position constants for the 4-bit flags word.
- One sub-module: wb_wait_counter, a clear/enable/terminal-count counter of width clog2(MAX_WAIT+1), reused later by the instruction-fetch stage.

Test Plan:
- Reset, then ADD accepted with alu_out=8'h2A, dest_reg=3, reg_write=1, zero_in=0, equal_in=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h2A, flags=4'b1000.
- CMP with reg_write=1, zero_in=1, beven_in=1 -> rf_we stays 0, flags bits [1:0]=2'b11; a following MOVE leaves flags unchanged.
- LOAD mem_addr_in=8'h10, memory acks 2 cycles after req with rdata=8'h5C -> mem_we=0 and address stable throughout, in_ready=0, one rf_we pulse with 8'h5C, then IDLE.
- STORE store_data=8'hA5 to 8'h20, ack on the first req cycle -> mem_we=1, mem_wdata=8'hA5, mem_req high exactly one cycle, no rf_we, in_ready back to 1 the next cycle.
- LOAD with no ack -> mem_req high MAX_WAIT (15) cycles then low, mem_err=1 held, no rf_we; a late ack is ignored; only Reset clears mem_err.
- Reset asserted while in MEM_REQ -> next cycle mem_req=0, rf_we=0, flags=0, in_ready=0; in_ready=1 the cycle after Reset deasserts.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the execute/writeback slice: opcodes, writeback FSM states
// and the bit layout of the architectural flags word.
package mem_wb_stage_pkg;

    localparam logic [2:0] kADD = 3'd0;
    localparam logic [2:0] kAND = 3'd1;
    localparam logic [2:0] kOR  = 3'd2;
    localparam logic [2:0] kXOR = 3'd3;
    localparam logic [2:0] kSHL = 3'd4;
    localparam logic [2:0] kSHR = 3'd5;
    localparam logic [2:0] kCMP = 3'd6;
    localparam logic [2:0] kSUB = 3'd7;

    localparam logic [1:0] kMOVE  = 2'd0;
    localparam logic [1:0] kFLAG  = 2'd1;
    localparam logic [1:0] kLOAD  = 2'd2;
    localparam logic [1:0] kSTORE = 2'd3;

    // flags word is {EQUAL, PARITY, BEVEN, ZERO}
    localparam int FLAG_W      = 4;
    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_BEVEN  = 1;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_EQUAL  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        LOAD_WB = 2'd2
    } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of the upstream result bus, data-memory handshake and register-file write port.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DW  = 8,
    parameter int RAW = 3,
    parameter int AW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    alu_out;
    logic [AW-1:0]    mem_addr_in;
    logic [DW-1:0]    store_data;
    logic             data_signifier;
    logic [2:0]       alu_op_code;
    logic [1:0]       data_op_code;
    logic [RAW-1:0]   dest_reg;
    logic             reg_write;
    logic             zero_in;
    logic             beven_in;
    logic             parity_in;
    logic             equal_in;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_ack;
    logic [DW-1:0]    mem_rdata;
    logic             rf_we;
    logic [RAW-1:0]   rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [FLAG_W-1:0] flags;
    logic             mem_err;

    modport slave (
        input  in_valid, alu_out, mem_addr_in, store_data, data_signifier,
               alu_op_code, data_op_code, dest_reg, reg_write,
               zero_in, beven_in, parity_in, equal_in, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, flags, mem_err
    );

    modport master (
        output in_valid, alu_out, mem_addr_in, store_data, data_signifier,
               alu_op_code, data_op_code, dest_reg, reg_write,
               zero_in, beven_in, parity_in, equal_in, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, flags, mem_err
    );

endinterface

// File: rtl/mem_wb_stage_wait_counter.sv
// Clear/enable counter whose terminal-count strobe fires on the enabled cycle that
// would bring the count up to MAX; clear has priority over enable.
module wb_wait_counter #(
    parameter int MAX = 15
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = i_en && (r_count == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: registers ALU results into the RF write port, owns the flags
// register and runs LOAD/STORE over a req/ack handshake with a bounded wait.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW       = 8,
    parameter int RAW      = 3,
    parameter int AW       = 8,
    parameter int MAX_WAIT = 15
) (
    input logic          Clk,
    input logic          Reset,
    mem_wb_stage_if.slave bus
);
    mem_wb_state_t     r_state, w_state_next;
    logic              r_mem_we;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic [RAW-1:0]    r_dest;
    logic              r_reg_write;
    logic              r_rf_we, w_rf_we_next;
    logic [RAW-1:0]    r_rf_waddr, w_rf_waddr_next;
    logic [DW-1:0]     r_rf_wdata, w_rf_wdata_next;
    logic [FLAG_W-1:0] r_flags, w_flags_next;
    logic              r_mem_err, w_mem_err_next;
    logic              w_latch;
    logic              w_accept;
    logic              w_is_mem;
    logic              w_is_cmp;
    logic              w_cnt_en;
    logic              w_cnt_clr;
    logic              w_tc;

    assign bus.in_ready = (r_state == IDLE) && !Reset;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_mem     = bus.data_signifier &&
                          ((bus.data_op_code == kLOAD) || (bus.data_op_code == kSTORE));
    assign w_is_cmp     = !bus.data_signifier && (bus.alu_op_code == kCMP);

    assign w_cnt_en  = (r_state == MEM_REQ) && !bus.mem_ack;
    assign w_cnt_clr = (r_state != MEM_REQ) || bus.mem_ack || w_tc;

    wb_wait_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .i_clk  (Clk),
        .i_srst (Reset),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_dest      <= '0;
            r_reg_write <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_flags     <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rf_we    <= w_rf_we_next;
            r_rf_waddr <= w_rf_waddr_next;
            r_rf_wdata <= w_rf_wdata_next;
            r_flags    <= w_flags_next;
            r_mem_err  <= w_mem_err_next;
            if (w_latch) begin
                r_mem_we    <= (bus.data_op_code == kSTORE);
                r_mem_addr  <= bus.mem_addr_in;
                r_mem_wdata <= bus.store_data;
                r_dest      <= bus.dest_reg;
                r_reg_write <= bus.reg_write;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rf_we_next    = 1'b0;
        w_rf_waddr_next = r_rf_waddr;
        w_rf_wdata_next = r_rf_wdata;
        w_flags_next    = r_flags;
        w_mem_err_next  = r_mem_err;
        w_latch         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem) begin
                        w_latch      = 1'b1;
                        w_state_next = MEM_REQ;
                    end else begin
                        // CMP only exists to update flags, so it never reaches the RF
                        w_rf_we_next    = bus.reg_write && !w_is_cmp;
                        w_rf_waddr_next = bus.dest_reg;
                        w_rf_wdata_next = bus.alu_out;
                        if (!bus.data_signifier) begin
                            w_flags_next[FLAG_ZERO]   = bus.zero_in;
                            w_flags_next[FLAG_BEVEN]  = bus.beven_in;
                            w_flags_next[FLAG_PARITY] = bus.parity_in;
                            w_flags_next[FLAG_EQUAL]  = bus.equal_in;
                        end
                    end
                end
            end
            MEM_REQ: begin
                if (bus.mem_ack) begin
                    if (r_mem_we) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next    = LOAD_WB;
                        w_rf_we_next    = r_reg_write;
                        w_rf_waddr_next = r_dest;
                        w_rf_wdata_next = bus.mem_rdata;
                    end
                end else if (w_tc) begin
                    w_state_next   = IDLE;
                    w_mem_err_next = 1'b1;
                end
            end
            LOAD_WB: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = (r_state == MEM_REQ);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.flags     = r_flags;
    assign bus.mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized mix
// checked against a transaction-level model (flags word and a memory array).
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DW(8), .RAW(3), .AW(8)) bus ();

    mem_wb_stage #(.DW(8), .RAW(3), .AW(8), .MAX_WAIT(15)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ds, input logic [2:0] aop, input logic [1:0] dop,
                            input logic [7:0] alu, input logic [7:0] addr, input logic [7:0] sd,
                            input logic [2:0] dest, input logic rw,
                            input logic z, input logic b, input logic p, input logic e);
        bus.data_signifier = ds;
        bus.alu_op_code    = aop;
        bus.data_op_code   = dop;
        bus.alu_out        = alu;
        bus.mem_addr_in    = addr;
        bus.store_data     = sd;
        bus.dest_reg       = dest;
        bus.reg_write      = rw;
        bus.zero_in        = z;
        bus.beven_in       = b;
        bus.parity_in      = p;
        bus.equal_in       = e;
        bus.in_valid       = 1'b1;
        step();
        bus.in_valid       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++;
        if ({bus.mem_req, bus.rf_we, bus.mem_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=000", {bus.mem_req, bus.rf_we, bus.mem_err});
        end
        n_checks++;
        if (bus.flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%h exp=0", bus.flags); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
        $display("txn reset: in_ready=%b flags=%h", bus.in_ready, bus.flags);
    endtask

    task automatic test_add();
        drive_op(1'b0, kADD, kMOVE, 8'h2A, 8'h00, 8'h00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 3'd3, 8'h2A}) begin
            n_fail++; $display("FAIL add_write got we=%b a=%0d d=%h exp we=1 a=3 d=2a", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.flags !== 4'b1000) begin n_fail++; $display("FAIL add_flags got=%b exp=1000", bus.flags); end
        $display("txn add: rf_we=%b rf_waddr=%0d rf_wdata=%h flags=%b", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.flags);
    endtask

    task automatic test_cmp();
        drive_op(1'b0, kCMP, kMOVE, 8'h11, 8'h00, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL cmp_no_write got=%b exp=0", bus.rf_we); end
        n_checks++;
        if (bus.flags !== 4'b0011) begin n_fail++; $display("FAIL cmp_flags got=%b exp=0011", bus.flags); end
        $display("txn cmp: rf_we=%b flags=%b", bus.rf_we, bus.flags);
        drive_op(1'b1, kADD, kMOVE, 8'h77, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 3'd6, 8'h77}) begin
            n_fail++; $display("FAIL move_write got we=%b a=%0d d=%h exp we=1 a=6 d=77", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.flags !== 4'b0011) begin n_fail++; $display("FAIL move_flags_kept got=%b exp=0011", bus.flags); end
        $display("txn move: rf_we=%b rf_wdata=%h flags=%b", bus.rf_we, bus.rf_wdata, bus.flags);
    endtask

    task automatic test_load();
        drive_op(1'b1, kADD, kLOAD, 8'h00, 8'h10, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5C; end
            n_checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.in_ready} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
                n_fail++; $display("FAIL load_req_cycle%0d got req=%b we=%b addr=%h rdy=%b exp req=1 we=0 addr=10 rdy=0",
                                   i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.in_ready);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'h00;
        n_checks++;
        if ({bus.mem_req, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.in_ready} !== {1'b0, 1'b1, 3'd5, 8'h5C, 1'b0}) begin
            n_fail++; $display("FAIL load_wb got req=%b we=%b a=%0d d=%h rdy=%b exp req=0 we=1 a=5 d=5c rdy=0",
                               bus.mem_req, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.in_ready);
        end
        step();
        n_checks++;
        if ({bus.rf_we, bus.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL load_idle got we=%b rdy=%b exp we=0 rdy=1", bus.rf_we, bus.in_ready);
        end
        $display("txn load: addr=10 data=5c done rdy=%b", bus.in_ready);
    endtask

    task automatic test_store();
        drive_op(1'b1, kADD, kSTORE, 8'h00, 8'h20, 8'hA5, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.mem_ack = 1'b1;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 8'h20, 8'hA5}) begin
            n_fail++; $display("FAIL store_req got req=%b we=%b addr=%h wd=%h exp req=1 we=1 addr=20 wd=a5",
                               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        bus.mem_ack = 1'b0;
        n_checks++;
        if ({bus.mem_req, bus.rf_we, bus.in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL store_done got req=%b we=%b rdy=%b exp req=0 we=0 rdy=1", bus.mem_req, bus.rf_we, bus.in_ready);
        end
        $display("txn store: addr=20 data=a5 rdy=%b", bus.in_ready);
    endtask

    task automatic test_timeout();
        int cnt;
        n_checks++;
        if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pre_err got=%b exp=0", bus.mem_err); end
        drive_op(1'b1, kADD, kLOAD, 8'h00, 8'h33, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (bus.mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            n_checks++;
            if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL timeout_rf_we cycle%0d got=%b exp=0", cnt, bus.rf_we); end
            step();
        end
        n_checks++;
        if (cnt != 15) begin n_fail++; $display("FAIL timeout_req_len got=%0d exp=15", cnt); end
        n_checks++;
        if ({bus.mem_err, bus.rf_we, bus.in_ready} !== 3'b101) begin
            n_fail++; $display("FAIL timeout_abort got err=%b we=%b rdy=%b exp err=1 we=0 rdy=1", bus.mem_err, bus.rf_we, bus.in_ready);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 8'hEE;
        step();
        bus.mem_ack = 1'b0;
        n_checks++;
        if ({bus.mem_err, bus.rf_we, bus.mem_req, bus.in_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL late_ack got err=%b we=%b req=%b rdy=%b exp err=1 we=0 req=0 rdy=1",
                               bus.mem_err, bus.rf_we, bus.mem_req, bus.in_ready);
        end
        drive_op(1'b0, kSUB, kMOVE, 8'h3C, 8'h00, 8'h00, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({bus.rf_we, bus.rf_wdata, bus.mem_err} !== {1'b1, 8'h3C, 1'b1}) begin
            n_fail++; $display("FAIL after_timeout got we=%b d=%h err=%b exp we=1 d=3c err=1", bus.rf_we, bus.rf_wdata, bus.mem_err);
        end
        $display("txn timeout: req_cycles=%0d mem_err=%b", cnt, bus.mem_err);
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, kADD, kLOAD, 8'h00, 8'h44, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req got=%b exp=1", bus.mem_req); end
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.mem_req, bus.rf_we, bus.flags, bus.in_ready, bus.mem_err} !== 8'h00) begin
            n_fail++; $display("FAIL rmid_state got req=%b we=%b fl=%h rdy=%b err=%b exp all 0",
                               bus.mem_req, bus.rf_we, bus.flags, bus.in_ready, bus.mem_err);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b exp=1", bus.in_ready); end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        n_checks++;
        if ({bus.rf_we, bus.mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_discard got we=%b req=%b exp 00", bus.rf_we, bus.mem_req);
        end
        $display("txn reset_mid: in_ready=%b mem_err=%b", bus.in_ready, bus.mem_err);
    endtask

    task automatic test_random();
        logic [7:0] mem_model [256];
        logic [3:0] flags_model;
        logic ds, rw, z, b, p, e, is_store, exp_we;
        logic [2:0] aop, dest;
        logic [1:0] dop;
        logic [7:0] alu, addr, sd, rd;
        int d;
        flags_model = 4'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        for (int t = 0; t < 40; t++) begin
            rw   = 1'($urandom);
            dest = 3'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                ds  = 1'($urandom);
                aop = ($urandom_range(0, 3) == 0) ? kCMP : 3'($urandom);
                dop = 2'($urandom_range(0, 1));
                alu = 8'($urandom);
                z = 1'($urandom); b = 1'($urandom); p = 1'($urandom); e = 1'($urandom);
                exp_we = rw && !(ds == 1'b0 && aop == kCMP);
                if (!ds) flags_model = {e, p, b, z};
                drive_op(ds, aop, dop, alu, 8'h00, 8'h00, dest, rw, z, b, p, e);
                n_checks++;
                if (bus.rf_we !== exp_we || (exp_we && {bus.rf_waddr, bus.rf_wdata} !== {dest, alu})) begin
                    n_fail++; $display("FAIL rnd%0d_alu got we=%b a=%0d d=%h exp we=%b a=%0d d=%h",
                                       t, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, dest, alu);
                end
                n_checks++;
                if (bus.flags !== flags_model) begin
                    n_fail++; $display("FAIL rnd%0d_flags got=%b exp=%b", t, bus.flags, flags_model);
                end
                $display("txn rnd%0d: ds=%b aop=%0d dop=%0d rf_we=%b flags=%b", t, ds, aop, dop, bus.rf_we, bus.flags);
            end else begin
                is_store = 1'($urandom);
                addr = 8'($urandom);
                sd   = 8'($urandom);
                d    = $urandom_range(0, 4);
                drive_op(1'b1, kADD, is_store ? kSTORE : kLOAD, 8'h00, addr, sd, dest, rw, 1'b0, 1'b0, 1'b0, 1'b0);
                for (int k = 0; k <= d; k++) begin
                    if (k == d) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = is_store ? 8'($urandom) : mem_model[addr];
                    end
                    n_checks++;
                    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.in_ready} !== {1'b1, is_store, addr, 1'b0} ||
                        (is_store && bus.mem_wdata !== sd)) begin
                        n_fail++; $display("FAIL rnd%0d_req got req=%b we=%b addr=%h wd=%h exp req=1 we=%b addr=%h wd=%h",
                                           t, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, is_store, addr, sd);
                    end
                    step();
                end
                bus.mem_ack = 1'b0;
                if (is_store) begin
                    mem_model[addr] = sd;
                    n_checks++;
                    if ({bus.mem_req, bus.rf_we, bus.in_ready} !== 3'b001) begin
                        n_fail++; $display("FAIL rnd%0d_store got req=%b we=%b rdy=%b exp 001", t, bus.mem_req, bus.rf_we, bus.in_ready);
                    end
                end else begin
                    rd = mem_model[addr];
                    n_checks++;
                    if (bus.rf_we !== rw || bus.in_ready !== 1'b0 || (rw && {bus.rf_waddr, bus.rf_wdata} !== {dest, rd})) begin
                        n_fail++; $display("FAIL rnd%0d_load got we=%b a=%0d d=%h rdy=%b exp we=%b a=%0d d=%h rdy=0",
                                           t, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.in_ready, rw, dest, rd);
                    end
                    step();
                    n_checks++;
                    if ({bus.rf_we, bus.in_ready} !== 2'b01) begin
                        n_fail++; $display("FAIL rnd%0d_load_end got we=%b rdy=%b exp 01", t, bus.rf_we, bus.in_ready);
                    end
                end
                $display("txn rnd%0d: %s addr=%h wait=%0d", t, is_store ? "store" : "load", addr, d);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.alu_out = '0; bus.mem_addr_in = '0; bus.store_data = '0;
        bus.data_signifier = 1'b0; bus.alu_op_code = '0; bus.data_op_code = '0;
        bus.dest_reg = '0; bus.reg_write = 1'b0; bus.zero_in = 1'b0; bus.beven_in = 1'b0;
        bus.parity_in = 1'b0; bus.equal_in = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_add();
        test_cmp();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
